regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of 2, 2..64); AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, read-port count (1..4).
REQ-004 SHALL have parameter NWR, default 1, write-port count (1..2).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port rr, input, NRD x AW, read addresses.
REQ-008 SHALL have port rdata, output, NRD x XLEN, read data.
REQ-009 SHALL have port rbusy, output, NRD, scoreboard busy flag per read address.
REQ-010 SHALL have port wr_en, input, NWR, write strobes.
REQ-011 SHALL have port wrr, input, NWR x AW, write addresses.
REQ-012 SHALL have port wrdata, input, NWR x XLEN, write data.
REQ-013 SHALL have port iss_en, input, 1, issue strobe, marks iss_rd pending.
REQ-014 SHALL have port iss_rd, input, AW, destination being issued.
REQ-015 SHALL have port busy_vec, output, NREGS, full scoreboard state.

Function
REQ-016 Writes SHALL commit on rising clk when wr_en[k]=1 and wrr[k]!=0.
REQ-017 Reads SHALL be combinational: rdata[j] = reg[rr[j]] same cycle.
REQ-018 Register 0 SHALL read 0 always; writes to 0 ignored and do not touch the scoreboard.
REQ-019 Same-cycle writes from both ports to one address: port 1 SHALL win; port 0 write dropped.
REQ-020 Scoreboard: iss_en=1, iss_rd!=0 SHALL set busy[iss_rd] at next edge.
REQ-021 Committed write to address a SHALL clear busy[a] at next edge.
REQ-022 Issue and write to same address same cycle: busy SHALL end set (issue wins).
REQ-023 rbusy[j] SHALL equal busy[rr[j]] combinationally; rbusy for rr[j]=0 SHALL be 0.
REQ-024 Issue to an already-busy register SHALL leave it busy (no count, no error).
REQ-025 busy_vec[0] SHALL be 0 always.

Reset
REQ-026 rst_n=0 at rising clk SHALL clear all registers to 0 and all busy bits to 0; outputs read 0 and rbusy=0 the following cycle.
REQ-027 Reset SHALL override same-cycle writes and issues.
REQ-028 Reset mid-operation SHALL discard pending state; no write SHALL commit in the reset cycle.

Configuration
REQ-029 Macro REGFILE_MP_BYPASS_EN defined: when wr_en[k]=1, wrr[k]=rr[j]!=0, rdata[j] SHALL return wrdata[k] same cycle (port 1 priority) and rbusy[j] SHALL read 0 unless iss_en to that address is also asserted.
REQ-030 Macro undefined: rdata SHALL return pre-write contents until the edge after the write; rbusy unaffected by in-flight writes.

Structure
REQ-031 Shared package regfile_pkg SHALL hold default XLEN/NREGS/NRD/NWR constants and typedef for register address and data words.
REQ-032 Scoreboard SHALL be a sub-module regfile_scoreboard (busy bits, set/clear priority); storage and read mux stay in regfile_mp.

Verification
REQ-033 Reset then read all 32 regs on both ports -> rdata=0, rbusy=0, busy_vec=0.
REQ-034 Write 0xDEADBEEF to x0, read x0 next cycle -> 0; busy_vec unchanged.
REQ-035 NWR=2: port0 writes 0x11111111 and port1 writes 0x22222222 to x5 same edge -> x5 reads 0x22222222.
REQ-036 Issue x7, then write 0xA5A5A5A5 to x7 two cycles later -> rbusy high for 2 cycles, clears after write edge, rdata=0xA5A5A5A5.
REQ-037 Issue and write x9 same cycle -> busy_vec[9]=1 after edge, x9=written value.
REQ-038 With REGFILE_MP_BYPASS_EN: write 0x12345678 to x3 while rr[0]=3 -> rdata[0]=0x12345678 same cycle; without macro -> old value, new value next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and word/address types for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 1;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_word_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: read ports, write ports, issue port, scoreboard view.
// master drives addresses/writes/issues; slave is the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF
);
    localparam int AW = $clog2(NREGS);

    logic [NRD-1:0][AW-1:0]   rr;
    logic [NRD-1:0][XLEN-1:0] rdata;
    logic [NRD-1:0]           rbusy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wrr;
    logic [NWR-1:0][XLEN-1:0] wrdata;
    logic                     iss_en;
    logic [AW-1:0]            iss_rd;
    logic [NREGS-1:0]         busy_vec;

    modport master (
        output rr, wr_en, wrr, wrdata, iss_en, iss_rd,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  rr, wr_en, wrr, wrdata, iss_en, iss_rd,
        output rdata, rbusy, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, x0 never busy.
// An issue to a register wins over a same-cycle committed write clearing it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_iss_en,
    input  logic [AW-1:0]    i_iss_rd,
    input  logic [NREGS-1:0] i_clr,
    output logic [NREGS-1:0] o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Next busy state: committed writes clear, issue sets afterwards so it wins.
    always_comb begin
        w_busy_nxt = r_busy & ~i_clr;
        if (i_iss_en && (i_iss_rd != '0)) begin
            w_busy_nxt[i_iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Busy bit register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads and a pending-write scoreboard.
// x0 is hard-wired to zero. On a same-address double write, the higher port wins.
// Optional macro REGFILE_MP_BYPASS_EN forwards same-cycle write data to the read
// ports and masks rbusy for registers being written (unless also being re-issued).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]          r_regs [NREGS];
    logic [NREGS-1:0]         w_wr_hit;
    logic [NREGS-1:0]         w_busy;
    logic [NRD-1:0][XLEN-1:0] w_rdata;
    logic [NRD-1:0]           w_rbusy;

    // One-hot map of registers receiving a committed write this cycle.
    always_comb begin
        w_wr_hit = '0;
        for (int k = 0; k < NWR; k++) begin
            if (bus.wr_en[k] && (bus.wrr[k] != '0)) begin
                w_wr_hit[bus.wrr[k]] = 1'b1;
            end
        end
    end

    // Storage update; later ports are assigned last, so they win on collisions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (bus.wr_en[k] && (bus.wrr[k] != '0)) begin
                    r_regs[bus.wrr[k]] <= bus.wrdata[k];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_iss_en (bus.iss_en),
        .i_iss_rd (bus.iss_rd),
        .i_clr    (w_wr_hit),
        .o_busy   (w_busy)
    );

    // Read mux per port, with optional write forwarding; x0 always reads zero, not busy.
    always_comb begin
        w_rdata = '0;
        w_rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            w_rdata[j] = r_regs[bus.rr[j]];
            w_rbusy[j] = w_busy[bus.rr[j]];
`ifdef REGFILE_MP_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (bus.wr_en[k] && (bus.wrr[k] == bus.rr[j])) begin
                    w_rdata[j] = bus.wrdata[k];
                    w_rbusy[j] = bus.iss_en && (bus.iss_rd == bus.rr[j]);
                end
            end
`endif
            if (bus.rr[j] == '0) begin
                w_rdata[j] = '0;
                w_rbusy[j] = 1'b0;
            end
        end
    end

    assign bus.rdata    = w_rdata;
    assign bus.rbusy    = w_rbusy;
    assign bus.busy_vec = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NWR=2, NRD=2) with an array-based reference model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    task automatic idle_inputs();
        bus.wr_en  = '0;
        bus.wrr    = '0;
        bus.wrdata = '0;
        bus.iss_en = 1'b0;
        bus.iss_rd = '0;
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic clock_edge();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (bus.wr_en[k] && bus.wrr[k] != 0) begin
                    m_regs[bus.wrr[k]] = bus.wrdata[k];
                    m_busy[bus.wrr[k]] = 1'b0;
                end
            end
            if (bus.iss_en && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
        end
        #1;
    endtask

    function automatic logic [XLEN-1:0] exp_rdata(input int j);
        int a;
        logic [XLEN-1:0] r;
        a = int'(bus.rr[j]);
        if (a == 0) return '0;
        r = m_regs[a];
`ifdef REGFILE_MP_BYPASS_EN
        for (int k = 0; k < NWR; k++)
            if (bus.wr_en[k] && int'(bus.wrr[k]) == a) r = bus.wrdata[k];
`endif
        return r;
    endfunction

    function automatic logic exp_rbusy(input int j);
        int a;
        logic b;
        a = int'(bus.rr[j]);
        if (a == 0) return 1'b0;
        b = m_busy[a];
`ifdef REGFILE_MP_BYPASS_EN
        for (int k = 0; k < NWR; k++)
            if (bus.wr_en[k] && int'(bus.wrr[k]) == a)
                b = bus.iss_en && int'(bus.iss_rd) == a;
`endif
        return b;
    endfunction

    function automatic logic [NREGS-1:0] exp_busy_vec();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.rr = '0;
        clock_edge();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.wr_en     = 2'b01;
            bus.wrr[0]    = AW'(c + 1);
            bus.wrdata[0] = $urandom;
            bus.iss_en    = 1'b1;
            bus.iss_rd    = AW'(c + 10);
            clock_edge();
        end
        rst_n         = 1'b0;
        bus.wr_en     = 2'b11;
        bus.wrr[0]    = 5'd5;
        bus.wrr[1]    = 5'd6;
        bus.wrdata[0] = $urandom;
        bus.wrdata[1] = $urandom;
        bus.iss_en    = 1'b1;
        bus.iss_rd    = 5'd12;
        clock_edge();
        rst_n = 1'b1;
        idle_inputs();
        for (int a = 0; a < NREGS; a++) begin
            bus.rr[0] = AW'(a);
            bus.rr[1] = AW'(NREGS - 1 - a);
            #2;
            checks++;
            if (bus.rdata[0] !== '0) begin
                failures++;
                $display("FAIL reset_rdata0 reg=%0d got=%h exp=0", a, bus.rdata[0]);
            end
            checks++;
            if (bus.rdata[1] !== '0) begin
                failures++;
                $display("FAIL reset_rdata1 reg=%0d got=%h exp=0", NREGS - 1 - a, bus.rdata[1]);
            end
            checks++;
            if (bus.rbusy !== 2'b00) begin
                failures++;
                $display("FAIL reset_rbusy reg=%0d got=%b exp=00", a, bus.rbusy);
            end
        end
        checks++;
        if (bus.busy_vec !== '0) begin
            failures++;
            $display("FAIL reset_busy_vec got=%h exp=0", bus.busy_vec);
        end
    endtask

    task automatic test_x0_write();
        bus.iss_en    = 1'b1;
        bus.iss_rd    = 5'd20;
        clock_edge();
        bus.wr_en     = 2'b11;
        bus.wrr[0]    = 5'd0;
        bus.wrr[1]    = 5'd0;
        bus.wrdata[0] = 32'hDEADBEEF;
        bus.wrdata[1] = $urandom;
        bus.iss_en    = 1'b1;
        bus.iss_rd    = 5'd0;
        clock_edge();
        idle_inputs();
        bus.rr[0] = 5'd0;
        bus.rr[1] = 5'd20;
        #2;
        checks++;
        if (bus.rdata[0] !== '0) begin
            failures++;
            $display("FAIL x0_rdata got=%h exp=0", bus.rdata[0]);
        end
        checks++;
        if (bus.busy_vec !== exp_busy_vec()) begin
            failures++;
            $display("FAIL x0_busy_vec got=%h exp=%h", bus.busy_vec, exp_busy_vec());
        end
        checks++;
        if (bus.busy_vec[0] !== 1'b0 || bus.busy_vec[20] !== 1'b1) begin
            failures++;
            $display("FAIL x0_busy_bits got0=%b got20=%b exp0=0 exp20=1", bus.busy_vec[0], bus.busy_vec[20]);
        end
    endtask

    task automatic test_dual_write();
        bus.wr_en     = 2'b11;
        bus.wrr[0]    = 5'd5;
        bus.wrr[1]    = 5'd5;
        bus.wrdata[0] = 32'h11111111;
        bus.wrdata[1] = 32'h22222222;
        clock_edge();
        idle_inputs();
        bus.rr[0] = 5'd5;
        bus.rr[1] = 5'd5;
        #2;
        checks++;
        if (bus.rdata[0] !== 32'h22222222) begin
            failures++;
            $display("FAIL dual_write_p0 got=%h exp=22222222", bus.rdata[0]);
        end
        checks++;
        if (bus.rdata[1] !== 32'h22222222) begin
            failures++;
            $display("FAIL dual_write_p1 got=%h exp=22222222", bus.rdata[1]);
        end
    endtask

    task automatic test_issue_then_write();
        logic exp_mid;
`ifdef REGFILE_MP_BYPASS_EN
        exp_mid = 1'b0;
`else
        exp_mid = 1'b1;
`endif
        bus.rr[0]  = 5'd7;
        bus.rr[1]  = 5'd0;
        bus.iss_en = 1'b1;
        bus.iss_rd = 5'd7;
        #2;
        checks++;
        if (bus.rbusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL issue_pre_rbusy got=%b exp=0", bus.rbusy[0]);
        end
        clock_edge();
        idle_inputs();
        #2;
        checks++;
        if (bus.rbusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL issue_c1_rbusy got=%b exp=1", bus.rbusy[0]);
        end
        clock_edge();
        bus.wr_en     = 2'b01;
        bus.wrr[0]    = 5'd7;
        bus.wrdata[0] = 32'hA5A5A5A5;
        #2;
        checks++;
        if (bus.rbusy[0] !== exp_mid) begin
            failures++;
            $display("FAIL issue_c2_rbusy got=%b exp=%b", bus.rbusy[0], exp_mid);
        end
        clock_edge();
        idle_inputs();
        #2;
        checks++;
        if (bus.rbusy[0] !== 1'b0 || bus.busy_vec[7] !== 1'b0) begin
            failures++;
            $display("FAIL issue_cleared got=%b/%b exp=0/0", bus.rbusy[0], bus.busy_vec[7]);
        end
        checks++;
        if (bus.rdata[0] !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL issue_rdata got=%h exp=a5a5a5a5", bus.rdata[0]);
        end
    endtask

    task automatic test_issue_write_same();
        logic [XLEN-1:0] v;
        v = $urandom;
        bus.iss_en    = 1'b1;
        bus.iss_rd    = 5'd9;
        bus.wr_en     = 2'b10;
        bus.wrr[1]    = 5'd9;
        bus.wrdata[1] = v;
        clock_edge();
        idle_inputs();
        bus.rr[0] = 5'd9;
        #2;
        checks++;
        if (bus.busy_vec[9] !== 1'b1 || bus.rbusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL same_issue_busy got=%b/%b exp=1/1", bus.busy_vec[9], bus.rbusy[0]);
        end
        checks++;
        if (bus.rdata[0] !== v) begin
            failures++;
            $display("FAIL same_issue_rdata got=%h exp=%h", bus.rdata[0], v);
        end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] old_v;
        logic [XLEN-1:0] exp_now;
        old_v = $urandom;
        bus.wr_en     = 2'b01;
        bus.wrr[0]    = 5'd3;
        bus.wrdata[0] = old_v;
        clock_edge();
        bus.wrdata[0] = 32'h12345678;
        bus.rr[0]     = 5'd3;
`ifdef REGFILE_MP_BYPASS_EN
        exp_now = 32'h12345678;
`else
        exp_now = old_v;
`endif
        #2;
        checks++;
        if (bus.rdata[0] !== exp_now) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h exp=%h", bus.rdata[0], exp_now);
        end
        clock_edge();
        idle_inputs();
        #2;
        checks++;
        if (bus.rdata[0] !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_next_cycle got=%h exp=12345678", bus.rdata[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            bus.wr_en = NWR'($urandom);
            for (int k = 0; k < NWR; k++) begin
                bus.wrr[k]    = AW'($urandom_range(0, 7));
                bus.wrdata[k] = $urandom;
            end
            bus.iss_en = ($urandom_range(0, 2) == 0);
            bus.iss_rd = AW'($urandom_range(0, 7));
            for (int j = 0; j < NRD; j++) bus.rr[j] = AW'($urandom_range(0, 7));
            #2;
            for (int j = 0; j < NRD; j++) begin
                checks++;
                if (bus.rdata[j] !== exp_rdata(j)) begin
                    failures++;
                    $display("FAIL rand_rdata cyc=%0d port=%0d got=%h exp=%h", c, j, bus.rdata[j], exp_rdata(j));
                end
                checks++;
                if (bus.rbusy[j] !== exp_rbusy(j)) begin
                    failures++;
                    $display("FAIL rand_rbusy cyc=%0d port=%0d got=%b exp=%b", c, j, bus.rbusy[j], exp_rbusy(j));
                end
            end
            checks++;
            if (bus.busy_vec !== exp_busy_vec()) begin
                failures++;
                $display("FAIL rand_busy_vec cyc=%0d got=%h exp=%h", c, bus.busy_vec, exp_busy_vec());
            end
            clock_edge();
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        bus.rr = '0;
        test_reset();
        test_x0_write();
        test_dual_write();
        test_issue_then_write();
        test_issue_write_same();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
